// File: rtl/sa_seq_pkg.sv
// Shared types and sizing helpers for the systolic-array tile sequencer.
package sa_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_LOAD_X,
    S_STORE,
    S_NEXT,
    S_FINISH
  } state_t;

  // Words per tile in each phase (weights, inputs, results).
  function automatic int tile_words(input int n);
    return n * n;
  endfunction

  function automatic int beat_width(input int n);
    return (n * n > 1) ? $clog2(n * n) : 1;
  endfunction

endpackage

// File: rtl/sa_seq_addr_gen.sv
// SRAM address generator: base + running tile offset + beat, all modulo 2^ADDR_W.
module sa_seq_addr_gen
  import sa_seq_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int N      = 4,
  parameter int BEAT_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base,
  input  logic [BEAT_W-1:0] beat,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(tile_words(N));

  logic [ADDR_W-1:0] tile_off;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        tile_off <= '0;
    else if (clear)   tile_off <= '0;
    else if (advance) tile_off <= tile_off + STEP;
  end

  assign addr = base + tile_off + ADDR_W'(beat);

endmodule

// File: rtl/sa_tile_sequencer.sv
// Sequences N*N tiles through the systolic array: load weights, load inputs, store results.
// Optional feature macro: SA_SEQ_WEIGHT_REUSE_EN (weights fetched once, in tile 0 only).
module sa_tile_sequencer
  import sa_seq_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int N      = 4,
  parameter int TILE_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [TILE_W-1:0] num_tiles,
  input  logic [ADDR_W-1:0] w_base,
  input  logic [ADDR_W-1:0] x_base,
  input  logic [ADDR_W-1:0] y_base,
  input  logic              valid_out,
  output logic              load_weights,
  output logic              load_inputs,
  output logic              store_outputs,
  output logic              sram_men,
  output logic              sram_ren,
  output logic              sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              busy,
  output logic              done
);

  localparam int                TW        = tile_words(N);
  localparam int                BEAT_W    = beat_width(N);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(TW - 1);

  state_t            state, state_nx;
  logic [BEAT_W-1:0] beat;
  logic [TILE_W-1:0] tile, num_q, tile_inc;
  logic [ADDR_W-1:0] w_q, x_q, y_q, base_sel, gen_addr;
  logic              ren, wen, accept;

  assign accept   = (state == S_IDLE) && start;
  assign tile_inc = tile + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      // An empty job still passes through NEXT so done lands two cycles after start.
      S_IDLE:   if (start) state_nx = (num_tiles == '0) ? S_NEXT : S_LOAD_W;
      S_LOAD_W: if (beat == LAST_BEAT) state_nx = S_LOAD_X;
      S_LOAD_X: if (beat == LAST_BEAT) state_nx = S_STORE;
      S_STORE:  if (valid_out && beat == LAST_BEAT) state_nx = S_NEXT;
      S_NEXT: begin
        if (tile_inc == num_q || num_q == '0) state_nx = S_FINISH;
        else begin
`ifdef SA_SEQ_WEIGHT_REUSE_EN
          state_nx = S_LOAD_X;
`else
          state_nx = S_LOAD_W;
`endif
        end
      end
      S_FINISH: state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    ren           = 1'b0;
    wen           = 1'b0;
    store_outputs = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    base_sel      = w_q;
    unique case (state)
      S_IDLE:   busy = 1'b0;
      S_LOAD_W: ren = 1'b1;
      S_LOAD_X: begin
        ren      = 1'b1;
        base_sel = x_q;
      end
      S_STORE: begin
        store_outputs = 1'b1;
        wen           = valid_out;
        base_sel      = y_q;
      end
      S_NEXT:   ;
      S_FINISH: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default:  busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat  <= '0;
      tile  <= '0;
      num_q <= '0;
      w_q   <= '0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      if (accept) begin
        num_q <= num_tiles;
        w_q   <= w_base;
        x_q   <= x_base;
        y_q   <= y_base;
        tile  <= '0;
        beat  <= '0;
      end else if (ren || wen) begin
        beat <= (beat == LAST_BEAT) ? '0 : beat + 1'b1;
      end
      if (state == S_NEXT) tile <= tile_inc;
    end
  end

  // Load strobes trail the read by one cycle to match SRAM read latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_weights <= 1'b0;
      load_inputs  <= 1'b0;
    end else begin
      load_weights <= (state == S_LOAD_W);
      load_inputs  <= (state == S_LOAD_X);
    end
  end

  sa_seq_addr_gen #(
    .ADDR_W (ADDR_W),
    .N      (N),
    .BEAT_W (BEAT_W)
  ) u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept),
    .advance (state == S_NEXT),
    .base    (base_sel),
    .beat    (beat),
    .addr    (gen_addr)
  );

  assign sram_ren  = ren;
  assign sram_wen  = wen;
  assign sram_men  = ren | wen;
  assign sram_addr = (ren || wen) ? gen_addr : '0;

endmodule
